// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared state encoding and sizing helper for the async FIFO side blocks
package async_fifo_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} arb_state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/async_fifo_wr_arb_if.sv
// async_fifo_wr_arb_if: requester handshakes plus the FIFO write port around the arbiter
interface async_fifo_wr_arb_if #(
   parameter int DW   = 8,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    i_req_valid;
   logic [NREQ*DW-1:0] i_req_data;
   logic [NREQ-1:0]    o_req_ready;
   logic [DW-1:0]      o_wr_data;
   logic               o_wr_valid;
   logic               i_wr_fifo_full;
   modport master (
      input  i_req_valid, i_req_data, i_wr_fifo_full,
      output o_req_ready, o_wr_data, o_wr_valid
   );
   modport slave (
      output i_req_valid, i_req_data, i_wr_fifo_full,
      input  o_req_ready, o_wr_data, o_wr_valid
   );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr (wrapping)
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);
   logic [PW-1:0] j;
   // scan farthest offset first so the nearest valid index from ptr wins
   always_comb begin
      idx = '0;
      j   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j   = PW'((int'(ptr) + k) % N);
         idx = req[j] ? j : idx;
      end
   end
   assign any = |req;
   assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/async_fifo_wr_arb.sv
// async_fifo_wr_arb: round-robin burst arbiter sharing the FIFO write port among NREQ requesters
module async_fifo_wr_arb
   import async_fifo_pkg::*;
#(
   parameter int DW        = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                sw_rst,
   async_fifo_wr_arb_if.master bus,
   output logic [NREQ-1:0]     o_gnt,
   output logic                o_busy,
   output logic [15:0]         o_xfer_cnt
);
   localparam int PW = clog2(NREQ);
   localparam int BW = clog2(MAX_BURST + 1);
   arb_state_t      state, state_n;
   logic [NREQ-1:0] gnt_n, p_gnt;
   logic [PW-1:0]   gidx, gidx_n, rr_ptr, rr_n, p_idx;
   logic [BW-1:0]   beat_cnt, beat_n;
   logic [15:0]     xfer_n;
   logic [DW-1:0]   g_data;
   logic            p_any, g_valid, accept, done, start;

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .req(bus.i_req_valid),
      .ptr(rr_ptr),
      .gnt(p_gnt),
      .idx(p_idx),
      .any(p_any)
   );

   always_comb begin
      g_data = '0;
      for (int i = 0; i < NREQ; i++) g_data = (PW'(i) == gidx) ? bus.i_req_data[i*DW +: DW] : g_data;
   end

   assign g_valid         = bus.i_req_valid[gidx];
   assign o_busy          = state == ST_BURST;
   assign start           = ~o_busy & p_any;
   assign accept          = o_busy & g_valid & ~bus.i_wr_fifo_full;
   // a requester gap or the last allowed beat hands the port to the next index
   assign done            = o_busy & (~g_valid | (accept & (beat_cnt == BW'(MAX_BURST - 1))));
   assign bus.o_wr_valid  = accept;
   assign bus.o_wr_data   = o_busy ? g_data : '0;
   assign bus.o_req_ready = accept ? o_gnt : '0;

   always_comb begin
      state_n = done ? ST_IDLE : start ? ST_BURST : state;
      gnt_n   = done ? '0 : start ? p_gnt : o_gnt;
      gidx_n  = start ? p_idx : gidx;
      rr_n    = done ? ((gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1) : rr_ptr;
      beat_n  = ~o_busy ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
      xfer_n  = o_xfer_cnt + 16'(accept);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         o_gnt      <= '0;
         gidx       <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         o_xfer_cnt <= '0;
      end else if (sw_rst) begin
         state      <= ST_IDLE;
         o_gnt      <= '0;
         gidx       <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         o_xfer_cnt <= '0;
      end else begin
         state      <= state_n;
         o_gnt      <= gnt_n;
         gidx       <= gidx_n;
         rr_ptr     <= rr_n;
         beat_cnt   <= beat_n;
         o_xfer_cnt <= xfer_n;
      end
   end
endmodule
